// File: rtl/rv32_pkg.sv
// Shared RV32 branch definitions: conditional-branch encoding and the
// 2-bit saturating counter states used by the branch history table.
package rv32_pkg;

  // Execute-stage branch_type encoding; BRES marks the reserved code 7.
  typedef enum logic [2:0] {
    NONE = 3'd0,
    BEQ  = 3'd1,
    BNE  = 3'd2,
    BLT  = 3'd3,
    BGE  = 3'd4,
    BLTU = 3'd5,
    BGEU = 3'd6,
    BRES = 3'd7
  } b_t;

  // Counter states: strongly/weakly not-taken, weakly/strongly taken.
  // Bit 1 of a counter is the taken prediction.
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch/execute-side bundle of the branch predictor. The pipeline drives
// the master side; branch_predict_unit sits on the slave side.
interface branch_predict_unit_if #(
  parameter int XLEN = 32
);

  // Fetch-side query
  logic [XLEN-1:0] fetch_pc;
  logic            predict_taken;

  // Execute-side resolution
  logic            resolve_valid;
  logic [XLEN-1:0] resolve_pc;
  logic [2:0]      branch_type;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            pred_taken_in;

  // Registered results toward the hazard unit
  logic            b_out;
  logic            mispredict;
  logic [31:0]     mispredict_count;

  modport master (
    output fetch_pc,
    output resolve_valid,
    output resolve_pc,
    output branch_type,
    output rs1_data,
    output rs2_data,
    output pred_taken_in,
    input  predict_taken,
    input  b_out,
    input  mispredict,
    input  mispredict_count
  );

  modport slave (
    input  fetch_pc,
    input  resolve_valid,
    input  resolve_pc,
    input  branch_type,
    input  rs1_data,
    input  rs2_data,
    input  pred_taken_in,
    output predict_taken,
    output b_out,
    output mispredict,
    output mispredict_count
  );

endinterface

// File: rtl/branch_cmp.sv
// Combinational RV32 conditional-branch resolver. Works directly on the
// raw operands: equality, signed and unsigned less-than are computed here,
// so no ALU flags are needed. Codes 0 and 7 are reported as non-branches.
module branch_cmp
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_branch_type,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_taken,
  output logic            o_is_branch
);

  logic signed [XLEN-1:0] w_rs1_s;
  logic signed [XLEN-1:0] w_rs2_s;
  logic                   w_eq;
  logic                   w_lt_s;
  logic                   w_lt_u;

  // Both operands are viewed as two's complement for BLT/BGE only.
  assign w_rs1_s = i_rs1;
  assign w_rs2_s = i_rs2;

  assign w_eq   = (i_rs1 == i_rs2);
  assign w_lt_s = (w_rs1_s < w_rs2_s);
  assign w_lt_u = (i_rs1 < i_rs2);

  // Select the condition for the encoded branch; unknown codes never take.
  always_comb begin
    o_taken     = 1'b0;
    o_is_branch = 1'b1;
    case (b_t'(i_branch_type))
      BEQ:  o_taken = w_eq;
      BNE:  o_taken = ~w_eq;
      BLT:  o_taken = w_lt_s;
      BGE:  o_taken = ~w_lt_s;
      BLTU: o_taken = w_lt_u;
      BGEU: o_taken = ~w_lt_u;
      default: begin
        o_taken     = 1'b0;
        o_is_branch = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor with execute-stage resolution.
// Fetch reads a direct-mapped table of 2-bit saturating counters indexed
// by the word address of the PC; execute resolves the branch through
// branch_cmp, trains the indexed counter and registers the taken flag, a
// one-cycle mispredict pulse and a saturating mispredict counter.
module branch_predict_unit
  import rv32_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CNT_INIT  = WNT
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_predict_unit_if.slave   bus
);

  localparam int IDXW = $clog2(BHT_DEPTH);

  // Counter moves one step toward strongly taken, holding at ST.
  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  // Counter moves one step toward strongly not-taken, holding at SNT.
  function automatic logic [1:0] sat_dec2(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

  // Performance counter increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc32(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic [1:0]      r_bht [BHT_DEPTH];

  logic [IDXW-1:0] w_fetch_idx;
  logic [IDXW-1:0] w_res_idx;
  logic            w_taken;
  logic            w_is_branch;
  logic            w_branch;
  logic            w_mis;
  logic            w_unused_pc;

  logic            r_b_out_p1;
  logic            r_mispredict_p1;
  logic [31:0]     r_mispredict_count;

  // Instructions are word aligned, so the index starts at bit 2; upper PC
  // bits alias onto the same counter by design.
  assign w_fetch_idx = bus.fetch_pc[IDXW+1:2];
  assign w_res_idx   = bus.resolve_pc[IDXW+1:2];
  assign w_unused_pc = ^{bus.fetch_pc[XLEN-1:IDXW+2],   bus.fetch_pc[1:0],
                         bus.resolve_pc[XLEN-1:IDXW+2], bus.resolve_pc[1:0]};

  branch_cmp #(
    .XLEN (XLEN)
  ) u_cmp (
    .i_branch_type (bus.branch_type),
    .i_rs1         (bus.rs1_data),
    .i_rs2         (bus.rs2_data),
    .o_taken       (w_taken),
    .o_is_branch   (w_is_branch)
  );

  assign w_branch = bus.resolve_valid & w_is_branch;
  assign w_mis    = w_taken ^ bus.pred_taken_in;

  // Prediction reads the table flops directly, so a same-cycle update to
  // the same index is seen by fetch only from the next cycle on.
  assign bus.predict_taken = r_bht[w_fetch_idx][1];

  // Table training: one saturating step per resolved branch; reset wins
  // over a resolve in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_bht[i] <= CNT_INIT;
      end
    end else if (w_branch) begin
      r_bht[w_res_idx] <= w_taken ? sat_inc2(r_bht[w_res_idx])
                                  : sat_dec2(r_bht[w_res_idx]);
    end
  end

  // ---- resolve (p0) -> registered result (p1) ----
  // Result flags are rewritten every cycle so the mispredict pulse can
  // never stretch past one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_b_out_p1      <= 1'b0;
      r_mispredict_p1 <= 1'b0;
    end else begin
      r_b_out_p1      <= w_branch & w_taken;
      r_mispredict_p1 <= w_branch & w_mis;
    end
  end

  // Mispredict performance counter, saturating rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mispredict_count <= 32'd0;
    end else if (w_branch && w_mis) begin
      r_mispredict_count <= sat_inc32(r_mispredict_count);
    end
  end

  assign bus.b_out            = r_b_out_p1;
  assign bus.mispredict       = r_mispredict_p1;
  assign bus.mispredict_count = r_mispredict_count;

endmodule
